mat_mult_seq: RTL and testbench
===============================

MAT_MULT_SEQ -- requirements
Module: mat_mult_seq

Interface
REQ-001 SHALL have parameter N, default 6, meaning matrix dimension (N x N operands).
REQ-002 SHALL have parameter W, default 27, meaning element width in bits.
REQ-003 SHALL have parameter LAT, default 8, meaning multiplier enable cycles per job (LAT >= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  host element write strobe.
REQ-007 SHALL have port wr_sel  input  1  write target: 0 = operand A, 1 = operand B.
REQ-008 SHALL have port wr_addr  input  $clog2(N*N)  row-major element index.
REQ-009 SHALL have port wr_data  input  W  element value.
REQ-010 SHALL have port start  input  1  single-cycle job start request.
REQ-011 SHALL have port rd_addr  input  $clog2(N*N)  result element index.
REQ-012 SHALL have port rd_data  output  W  registered result element.
REQ-013 SHALL have port busy  output  1  job in progress.
REQ-014 SHALL have port done  output  1  result buffer valid, level.
REQ-015 SHALL have port wr_err  output  1  one-cycle pulse, rejected write.
REQ-016 SHALL have ports mm_en, mm_rst  output  1 each  multiplier enable and clear.
REQ-017 SHALL have ports mm_dataa, mm_datab  output  [N*N-1:0][W-1:0]  operand buses.
REQ-018 SHALL have port mm_result  input  [N*N-1:0][W-1:0]  multiplier product bus.

Function
REQ-019 SHALL hold A, B and result buffers of N*N W-bit registers; mm_dataa/mm_datab driven directly from A/B registers.
REQ-020 SHALL implement FSM states IDLE, CLR, RUN, CAPT.
REQ-021 IDLE: start=1 -> CLR; otherwise stay.
REQ-022 CLR: exactly 1 cycle, mm_rst=1, mm_en=0; -> RUN.
REQ-023 RUN: mm_en=1 for exactly LAT consecutive cycles, counted by a down-counter loaded with LAT-1 on CLR exit; -> CAPT when counter = 0.
REQ-024 CAPT: 1 cycle, mm_en=0; result buffer latches mm_result at the end of this cycle; -> IDLE.
REQ-025 Timing: start sampled at edge 0 -> CLR in cycle 1, RUN in cycles 2..LAT+1, CAPT in cycle LAT+2, done=1 and busy=0 from cycle LAT+3.
REQ-026 busy SHALL be 1 in CLR, RUN, CAPT; 0 in IDLE.
REQ-027 done SHALL clear on the edge accepting start and set on CAPT exit; it stays 1 until the next accepted start or reset.
REQ-028 Write in IDLE with wr_addr < N*N SHALL update A[wr_addr] (wr_sel=0) or B[wr_addr] (wr_sel=1) on that edge.
REQ-029 Write while busy or with wr_addr >= N*N SHALL be ignored and SHALL assert wr_err for the following cycle.
REQ-030 Simultaneous wr_en and start in IDLE: the write SHALL commit, and the job SHALL use the updated value.
REQ-031 start while busy SHALL be ignored with no error and no queuing.
REQ-032 rd_data SHALL equal result[rd_addr] one cycle after rd_addr is presented; rd_addr >= N*N SHALL return 0; reads are permitted in any state and return the previous result while busy.
REQ-033 Outside CLR, mm_rst SHALL equal rst; mm_en SHALL be 0 outside RUN.

Reset
REQ-034 rst=1 SHALL asynchronously force: state IDLE, counter 0, A/B/result buffers 0, rd_data 0, busy 0, done 0, wr_err 0, mm_en 0, mm_rst 1.
REQ-035 Reset mid-job SHALL abort the job with no result capture, and done SHALL remain 0 after release.
REQ-036 After rst deassertion, the first start SHALL be accepted on the next rising edge.

Verification
REQ-037 Identity job: write A = I6 and B[k] = k, then start; stub returns A*B after LAT cycles -> mm_rst high in cycle 1, mm_en high in cycles 2..9, done=1 at cycle 11, rd_addr=7 -> rd_data=7.
REQ-038 Write protection: wr_en with wr_addr=36, then write during RUN -> wr_err pulses once each; A/B unchanged (readback via mm_dataa).
REQ-039 Same-cycle write+start: A[0]=5 written with start -> mm_dataa[0]=5 during CLR.
REQ-040 start asserted every cycle for 30 cycles -> exactly two jobs complete (11 cycles each, back-to-back), busy never drops mid-job.
REQ-041 rst pulsed in RUN cycle 4 -> all outputs at reset values asynchronously; done=0; a subsequent job completes normally.
REQ-042 rd_addr=40 -> rd_data=0; old result remains readable while a second job is busy.

Source files
------------

// File: rtl/mat_mult_seq.sv
// Sequential matrix-multiply job controller: holds A/B operand and result buffers,
// sequences an external multiplier through clear/run/capture, and serves result reads.
module mat_mult_seq #(
  parameter int unsigned N   = 6,
  parameter int unsigned W   = 27,
  parameter int unsigned LAT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [$clog2(N*N)-1:0]         wr_addr,
  input  logic [W-1:0]                   wr_data,
  input  logic                           start,
  input  logic [$clog2(N*N)-1:0]         rd_addr,
  output logic [W-1:0]                   rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           wr_err,
  output logic                           mm_en,
  output logic                           mm_rst,
  output logic [N*N-1:0][W-1:0]          mm_dataa,
  output logic [N*N-1:0][W-1:0]          mm_datab,
  input  logic [N*N-1:0][W-1:0]          mm_result
);

  localparam int unsigned NN = N * N;
  localparam int unsigned AW = $clog2(NN);
  localparam int unsigned CW = $clog2(LAT + 1);
  localparam logic [AW:0] NN_LIM = (AW + 1)'(NN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    CAPT
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    wr_err_q;
  logic                    mm_en_q;
  logic                    clr_q;
  logic [NN-1:0][W-1:0]    a_q;
  logic [NN-1:0][W-1:0]    b_q;
  logic [NN-1:0][W-1:0]    res_q;
  logic [W-1:0]            rd_data_q;

  logic                    idle;
  logic                    wr_addr_ok;
  logic                    rd_addr_ok;
  logic                    wr_ok;
  logic                    start_ok;

  always_comb begin
    idle       = (state_q == IDLE);
    wr_addr_ok = ({1'b0, wr_addr} < NN_LIM);
    rd_addr_ok = ({1'b0, rd_addr} < NN_LIM);
    wr_ok      = wr_en && idle && wr_addr_ok;
    start_ok   = start && idle;
  end

  // A write and a start on the same IDLE edge both take effect, so CLR already
  // presents the freshly written operand on mm_dataa/mm_datab.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      mm_en_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= CLR;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            clr_q   <= 1'b1;
          end
        end
        CLR: begin
          state_q <= RUN;
          cnt_q   <= CNT_LOAD;
          clr_q   <= 1'b0;
          mm_en_q <= 1'b1;
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= CAPT;
            mm_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CAPT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          mm_en_q <= 1'b0;
          clr_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (wr_ok) begin
        if (wr_sel) begin
          b_q[wr_addr] <= wr_data;
        end else begin
          a_q[wr_addr] <= wr_data;
        end
      end
      if (state_q == CAPT) begin
        res_q <= mm_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_addr_ok ? res_q[rd_addr] : '0;
    end
  end

  // Multiplier clear follows the chip reset directly so it is held for the whole reset.
  assign mm_rst   = rst | clr_q;
  assign mm_en    = mm_en_q;
  assign mm_dataa = a_q;
  assign mm_datab = b_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq with a behavioural multiplier stub and a
// matrix-level reference model of operand writes and job results.
module tb_mat_mult_seq;

  localparam int unsigned N   = 6;
  localparam int unsigned W   = 27;
  localparam int unsigned LAT = 8;
  localparam int unsigned NN  = N * N;
  localparam int unsigned AW  = $clog2(NN);

  typedef logic [NN-1:0][W-1:0] bus_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic          mm_en;
  logic          mm_rst;
  bus_t          mm_dataa;
  bus_t          mm_datab;
  bus_t          mm_result;

  int n_tests = 0;
  int n_fail  = 0;

  bus_t m_a, m_b, m_res;
  bit   job_active = 1'b0;

  mat_mult_seq #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .mm_en     (mm_en),
    .mm_rst    (mm_rst),
    .mm_dataa  (mm_dataa),
    .mm_datab  (mm_datab),
    .mm_result (mm_result)
  );

  always #5 clk = ~clk;

  function automatic bus_t matmul(bus_t a, bus_t b);
    bus_t c;
    longint unsigned acc;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          acc += longint'(a[i*N+k]) * longint'(b[k*N+j]);
        end
        c[i*N+j] = W'(acc);
      end
    end
    return c;
  endfunction

  // Multiplier stub: product only appears after the LAT-th enable following a clear.
  int stub_cnt;
  always_ff @(posedge clk) begin
    if (mm_rst) begin
      stub_cnt  <= 0;
      mm_result <= '1;
    end else if (mm_en) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == LAT - 1) mm_result <= matmul(mm_dataa, mm_datab);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input bit sel, input int unsigned addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < NN && !job_active) begin
      if (sel) m_b[addr] = data;
      else     m_a[addr] = data;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NN; i++) begin
      do_write(1'b0, i, W'($urandom));
      do_write(1'b1, i, W'($urandom));
    end
  endtask

  task automatic read_elem(input int unsigned addr, output logic [W-1:0] v);
    rd_addr = AW'(addr);
    tick();
    v = rd_data;
  endtask

  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1'b1;
    for (int k = 0; k < LAT + 20; k++) begin
      if (done === 1'b1 && busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic run_job(output int cyc, output bit timed_out);
    bus_t exp;
    exp = matmul(m_a, m_b);
    job_active = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, timed_out);
    job_active = 1'b0;
    m_res = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({rd_data, busy, done, wr_err, mm_en, mm_rst} !== {{W{1'b0}}, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%0h b=%b d=%b e=%b en=%b r=%b", rd_data, busy, done, wr_err, mm_en, mm_rst);
    end
    n_tests++;
    if (mm_dataa !== '0 || mm_datab !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: operand buses nonzero, required 0");
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (mm_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_mm_rst: got %b required 0", mm_rst);
    end
  endtask

  task automatic test_identity();
    logic [W-1:0] v;
    bus_t exp;
    int bad;
    for (int i = 0; i < NN; i++) begin
      do_write(1'b0, i, (i / N == i % N) ? W'(1) : W'(0));
      do_write(1'b1, i, W'(i));
    end
    exp = matmul(m_a, m_b);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({mm_rst, mm_en, busy, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ident_clr: got rst/en/busy/done=%b%b%b%b required 1010", mm_rst, mm_en, busy, done);
    end
    for (int c = 2; c <= LAT + 1; c++) begin
      tick();
      n_tests++;
      if ({mm_rst, mm_en, busy, done} !== 4'b0110) begin
        n_fail++;
        $display("FAIL ident_run_c%0d: got rst/en/busy/done=%b%b%b%b required 0110", c, mm_rst, mm_en, busy, done);
      end
    end
    tick();
    n_tests++;
    if ({mm_rst, mm_en, busy, done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL ident_capt: got rst/en/busy/done=%b%b%b%b required 0010", mm_rst, mm_en, busy, done);
    end
    tick();
    n_tests++;
    if ({busy, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL ident_done: got busy/done=%b%b required 01", busy, done);
    end
    m_res = exp;
    read_elem(7, v);
    n_tests++;
    if (v !== W'(7)) begin
      n_fail++;
      $display("FAIL ident_rd7: got %0d required 7", v);
    end
    bad = 0;
    for (int i = 0; i < NN; i++) begin
      read_elem(i, v);
      if (v !== m_res[i]) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ident_all: %0d elements wrong, required 0", bad);
    end
  endtask

  task automatic test_random_jobs();
    logic [W-1:0] v;
    int cyc, bad;
    bit to;
    for (int t = 0; t < 3; t++) begin
      load_random();
      run_job(cyc, to);
      n_tests++;
      if (to || cyc != LAT + 2) begin
        n_fail++;
        $display("FAIL rand_latency_%0d: got %0d cycles (timeout=%b) required %0d", t, cyc, to, LAT + 2);
      end
      bad = 0;
      for (int i = 0; i < NN; i++) begin
        read_elem(i, v);
        if (v !== m_res[i]) begin
          bad++;
          if (bad == 1) $display("FAIL rand_elem_%0d_%0d: got %0h required %0h", t, i, v, m_res[i]);
        end
      end
      n_tests++;
      if (bad != 0) n_fail++;
    end
  endtask

  task automatic test_write_protect();
    int cyc;
    bit to;
    bus_t exp;
    do_write(1'b0, 36, W'($urandom));
    n_tests++;
    if (wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_oob_err: got %b required 1", wr_err);
    end
    tick();
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wp_oob_pulse: got %b required 0", wr_err);
    end
    do_write(1'b1, 63, W'($urandom));
    do_write(1'b0, 5, W'($urandom));
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wp_valid_noerr: got %b required 0", wr_err);
    end
    n_tests++;
    if (mm_dataa !== m_a || mm_datab !== m_b) begin
      n_fail++;
      $display("FAIL wp_oob_unchanged: operand buses differ from model");
    end
    exp = matmul(m_a, m_b);
    job_active = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    do_write(1'b1, 3, ~m_b[3]);
    n_tests++;
    if (wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_busy_err: got %b required 1", wr_err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wp_busy_pulse: got %b required 0", wr_err);
    end
    n_tests++;
    if (mm_dataa !== m_a || mm_datab !== m_b) begin
      n_fail++;
      $display("FAIL wp_busy_unchanged: operand buses differ from model");
    end
    wait_done(cyc, to);
    job_active = 1'b0;
    m_res = exp;
    tick();
    tick();
    tick();
    n_tests++;
    if (to || {busy, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL wp_no_queued_job: got busy/done=%b%b timeout=%b required 01", busy, done, to);
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] v;
    int cyc, bad;
    bit to;
    bus_t exp;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = W'(5);
    start = 1'b1;
    m_a[0] = W'(5);
    exp = matmul(m_a, m_b);
    job_active = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    n_tests++;
    if (mm_dataa[0] !== W'(5) || mm_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_a0: got a0=%0d mm_rst=%b required 5,1", mm_dataa[0], mm_rst);
    end
    wait_done(cyc, to);
    job_active = 1'b0;
    m_res = exp;
    bad = 0;
    for (int i = 0; i < NN; i++) begin
      read_elem(i, v);
      if (v !== m_res[i]) bad++;
    end
    n_tests++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL same_cycle_result: %0d wrong elements, timeout=%b, required 0", bad, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    int completions, cyc, bad;
    bit prev_done, to;
    bus_t exp;
    load_random();
    exp = matmul(m_a, m_b);
    completions = 0;
    prev_done = done;
    job_active = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_tests++;
      if (busy !== (c % 11 != 0) || done !== (c % 11 == 0)) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got busy/done=%b%b required %b%b", c, busy, done, c % 11 != 0, c % 11 == 0);
      end
      if (done === 1'b1 && !prev_done) completions++;
      prev_done = done;
      if (c == 30) start = 1'b0;
    end
    n_tests++;
    if (completions != 2) begin
      n_fail++;
      $display("FAIL b2b_jobs: got %0d completions required 2", completions);
    end
    wait_done(cyc, to);
    job_active = 1'b0;
    m_res = exp;
    bad = 0;
    for (int i = 0; i < NN; i += 5) begin
      read_elem(i, v);
      if (v !== m_res[i]) bad++;
    end
    n_tests++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_result: %0d wrong elements, timeout=%b, required 0", bad, to);
    end
  endtask

  task automatic test_rst_mid_job();
    logic [W-1:0] v;
    int cyc, bad;
    bit to;
    load_random();
    run_job(cyc, to);
    read_elem(1, v);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, wr_err, mm_en, mm_rst} !== 5'b00001 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got b=%b d=%b e=%b en=%b r=%b rd=%0h required 00001,0", busy, done, wr_err, mm_en, mm_rst, rd_data);
    end
    n_tests++;
    if (mm_dataa !== '0 || mm_datab !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_operands: operand buses nonzero, required 0");
    end
    m_a = '0; m_b = '0; m_res = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_done_low: got busy/done=%b%b required 00", busy, done);
    end
    read_elem(1, v);
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_no_capture: got %0h required 0", v);
    end
    load_random();
    run_job(cyc, to);
    bad = 0;
    for (int i = 0; i < NN; i++) begin
      read_elem(i, v);
      if (v !== m_res[i]) bad++;
    end
    n_tests++;
    if (to || cyc != LAT + 2 || bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid_next_job: %0d wrong, %0d cycles, timeout=%b, required 0,%0d,0", bad, cyc, to, LAT + 2);
    end
  endtask

  task automatic test_oob_busy_read();
    logic [W-1:0] v;
    int cyc, bad;
    bit to;
    bus_t exp;
    read_elem(40, v);
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL rd_oob_40: got %0h required 0", v);
    end
    read_elem(63, v);
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL rd_oob_63: got %0h required 0", v);
    end
    for (int i = 0; i < NN; i++) do_write(1'b1, i, W'($urandom));
    exp = matmul(m_a, m_b);
    job_active = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      read_elem(i * 7, v);
      if (v !== m_res[i*7] || busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rd_old_while_busy: %0d bad reads, required 0", bad);
    end
    wait_done(cyc, to);
    job_active = 1'b0;
    m_res = exp;
    bad = 0;
    for (int i = 0; i < NN; i++) begin
      read_elem(i, v);
      if (v !== m_res[i]) bad++;
    end
    n_tests++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL rd_new_result: %0d wrong elements, timeout=%b, required 0", bad, to);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rd_addr = '0;
    m_a = '0; m_b = '0; m_res = '0;
    test_reset();
    test_identity();
    test_random_jobs();
    test_write_protect();
    test_same_cycle();
    test_back_to_back();
    test_rst_mid_job();
    test_oob_busy_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
